bus_stall_bridge: RTL and testbench

Single-clock bridge on the CPU-side bus, directly downstream of the CPU bus master, in front of slow peripherals that assert a busy flag. It detects accesses to a configured address window and freezes the CPU through its halt input while the peripheral finishes. It forwards a registered one-cycle request and returns captured read data. An optional watchdog aborts accesses that stay busy too long.

---
 rtl/bus_stall_bridge_pkg.sv | 34 +++
 rtl/bus_stall_bridge_timeout.sv | 37 +++
 rtl/bus_stall_bridge.sv | 138 +++++++++++++
 tb/tb_bus_stall_bridge.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_stall_bridge_pkg.sv
// cpu_reg_package: shared bus widths, bridge state type and error read value for
// bus_stall_bridge and its watchdog sub-module.
//   address_width      CPU/peripheral address width
//   data_width         CPU/peripheral data width
//   bus_stall_state_t  bridge FSM state (IDLE, ISSUE, WAIT, DONE)
//   BUS_STALL_ERR_DATA read value returned when an access is aborted
//   addr_in_window()   window decode, evaluated one bit wider so base+size cannot wrap
package cpu_reg_package;

   localparam int unsigned address_width = 32;
   localparam int unsigned data_width    = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } bus_stall_state_t;

   localparam logic [data_width-1:0] BUS_STALL_ERR_DATA = '1;

   function automatic logic addr_in_window(input logic [address_width-1:0] addr,
                                           input logic [address_width-1:0] base,
                                           input logic [address_width:0]   size);
      logic [address_width:0] a;
      logic [address_width:0] lo;
      logic [address_width:0] hi;
      a  = {1'b0, addr};
      lo = {1'b0, base};
      hi = lo + size;
      return (a >= lo) && (a < hi);
   endfunction

endpackage

// File: rtl/bus_stall_bridge_timeout.sv
// bus_stall_timeout: WAIT-state watchdog counter for bus_stall_bridge.
// Only instantiated when BUS_STALL_TIMEOUT_EN is defined.
//   clk_i      system clock
//   reset_i    synchronous active-high reset
//   clear_i    restart the count (asserted in the cycle before WAIT is entered)
//   count_i    advance the count (asserted in every WAIT cycle)
//   expired_o  count has reached TIMEOUT_CYCLES-1
module bus_stall_timeout
   import cpu_reg_package::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic clear_i,
   input  logic count_i,
   output logic expired_o
);

   localparam int unsigned CountWidth = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CountWidth-1:0] CountLast = CountWidth'(TIMEOUT_CYCLES - 1);

   logic [CountWidth-1:0] count_q;

   assign expired_o = (count_q == CountLast);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q <= '0;
      end else if (clear_i) begin
         count_q <= '0;
      end else if (count_i && !expired_o) begin
         count_q <= count_q + 1'b1;
      end
   end

endmodule

// File: rtl/bus_stall_bridge.sv
// bus_stall_bridge: halts the CPU while an access to a slow peripheral window completes.
// An in-window access latches address/we/data, issues a one-cycle per_req_o, waits for
// per_busy_i to drop, captures per_data_i into cpu_data_o and releases the CPU.
// Optional feature macro: BUS_STALL_TIMEOUT_EN (WAIT watchdog, sticky timeout_o).
//   clk_i, reset_i             clock, synchronous active-high reset
//   cpu_address_i/we_i/data_i  CPU bus request
//   cpu_data_o, cpu_halt_o     captured read data, CPU freeze (combinational in IDLE)
//   per_address_o/we_o/data_o  latched request toward the peripheral
//   per_req_o                  one-cycle request pulse
//   per_data_i, per_busy_i     peripheral read data and busy
//   timeout_o                  sticky watchdog flag (0 without the macro)
module bus_stall_bridge
   import cpu_reg_package::*;
#(
   parameter logic [address_width-1:0] BASE_ADDR      = 32'h9000,
   parameter logic [address_width:0]   WINDOW_SIZE    = 33'h100,
   parameter int unsigned              TIMEOUT_CYCLES = 1024
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [address_width-1:0] cpu_address_i,
   input  logic                     cpu_we_i,
   input  logic [data_width-1:0]    cpu_data_i,
   output logic [data_width-1:0]    cpu_data_o,
   output logic                     cpu_halt_o,
   output logic [address_width-1:0] per_address_o,
   output logic                     per_we_o,
   output logic [data_width-1:0]    per_data_o,
   output logic                     per_req_o,
   input  logic [data_width-1:0]    per_data_i,
   input  logic                     per_busy_i,
   output logic                     timeout_o
);

   bus_stall_state_t         state_q;
   logic                     served_q;
   logic [address_width-1:0] lat_addr_q;
   logic                     lat_we_q;
   logic [data_width-1:0]    lat_data_q;
   logic                     per_req_q;
   logic [data_width-1:0]    cpu_data_q;
   logic                     in_win;
   logic                     hit;

   // served suppresses a re-hit while the CPU still presents the address just completed
   assign in_win = addr_in_window(cpu_address_i, BASE_ADDR, WINDOW_SIZE);
   assign hit    = in_win && !(served_q && (cpu_address_i == lat_addr_q));

   always_comb begin
      cpu_halt_o = 1'b0;
      if (state_q == IDLE) begin
         cpu_halt_o = hit;
      end else begin
         cpu_halt_o = (state_q != DONE);
      end
   end

   assign per_address_o = lat_addr_q;
   assign per_we_o      = lat_we_q;
   assign per_data_o    = lat_data_q;
   assign per_req_o     = per_req_q;
   assign cpu_data_o    = cpu_data_q;

`ifdef BUS_STALL_TIMEOUT_EN
   logic timer_expired;
   logic timeout_q;

   bus_stall_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .clear_i  (state_q == ISSUE),
      .count_i  (state_q == WAIT),
      .expired_o(timer_expired)
   );

   assign timeout_o = timeout_q;
`else
   logic unused_timeout_cycles;
   assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
   assign timeout_o = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         served_q   <= 1'b0;
         lat_addr_q <= '0;
         lat_we_q   <= 1'b0;
         lat_data_q <= '0;
         per_req_q  <= 1'b0;
         cpu_data_q <= '0;
`ifdef BUS_STALL_TIMEOUT_EN
         timeout_q  <= 1'b0;
`endif
      end else begin
         per_req_q <= 1'b0;
         if (cpu_address_i != lat_addr_q) begin
            served_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (hit) begin
                  lat_addr_q <= cpu_address_i;
                  lat_we_q   <= cpu_we_i;
                  lat_data_q <= cpu_data_i;
                  per_req_q  <= 1'b1;
                  state_q    <= ISSUE;
               end
            end
            ISSUE: begin
               state_q <= WAIT;
            end
            WAIT: begin
               if (!per_busy_i) begin
                  cpu_data_q <= per_data_i;
                  state_q    <= DONE;
               end
`ifdef BUS_STALL_TIMEOUT_EN
               else if (timer_expired) begin
                  cpu_data_q <= BUS_STALL_ERR_DATA;
                  timeout_q  <= 1'b1;
                  state_q    <= DONE;
               end
`endif
            end
            DONE: begin
               // set wins over the address-change clear in this cycle
               served_q <= 1'b1;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_stall_bridge.sv
// Directed bench for bus_stall_bridge (window 'h9000..'h90FF, TIMEOUT_CYCLES=16).
module tb_bus_stall_bridge;
   import cpu_reg_package::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] cpu_address;
   logic        cpu_we;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_halt;
   logic [31:0] per_address;
   logic        per_we;
   logic [31:0] per_wdata;
   logic        per_req;
   logic [31:0] per_rdata;
   logic        per_busy;
   logic        timeout;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   bus_stall_bridge #(
      .BASE_ADDR     (32'h9000),
      .WINDOW_SIZE   (33'h100),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk_i        (clk),
      .reset_i      (reset),
      .cpu_address_i(cpu_address),
      .cpu_we_i     (cpu_we),
      .cpu_data_i   (cpu_wdata),
      .cpu_data_o   (cpu_rdata),
      .cpu_halt_o   (cpu_halt),
      .per_address_o(per_address),
      .per_we_o     (per_we),
      .per_data_o   (per_wdata),
      .per_req_o    (per_req),
      .per_data_i   (per_rdata),
      .per_busy_i   (per_busy),
      .timeout_o    (timeout)
   );

   // Drives one access from cycle N (first sampled cycle) and observes it until the first
   // non-halted cycle after a halt (the DONE cycle) or max_cyc cycles.
   // busy_n = number of WAIT cycles with busy high, counted from the cycle after the request.
   task automatic run_access(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                             input int busy_n, input logic [31:0] rdata, input int max_cyc,
                             output int halt_n, output int req_n, output int req_at,
                             output logic [31:0] r_addr, output logic r_we,
                             output logic [31:0] r_data, output logic [31:0] done_data,
                             output logic to_done);
      int   since_req;
      logic seen_halt;
      halt_n = 0; req_n = 0; req_at = -1; r_addr = 'x; r_we = 1'bx; r_data = 'x;
      done_data = 'x; to_done = 1'bx; since_req = -1; seen_halt = 1'b0;
      @(posedge clk); #1;
      cpu_address = addr; cpu_we = we; cpu_wdata = wdata; per_rdata = rdata; per_busy = 1'b0;
      for (int c = 0; c < max_cyc; c++) begin
         @(negedge clk);
         if (cpu_halt) begin
            halt_n++;
            seen_halt = 1'b1;
         end else if (seen_halt) begin
            done_data = cpu_rdata;
            to_done   = timeout;
            break;
         end
         if (per_req) begin
            req_n++;
            req_at = c; r_addr = per_address; r_we = per_we; r_data = per_wdata;
            since_req = 0;
         end
         @(posedge clk); #1;
         if (since_req >= 0) begin
            since_req++;
            per_busy = (since_req <= busy_n);
         end
      end
      per_busy = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; cpu_address = '0; cpu_we = 1'b0; cpu_wdata = '0;
      per_rdata = '0; per_busy = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++; if (cpu_halt !== 1'b0) begin errors++; $display("FAIL reset_halt: got %b want 0", cpu_halt); end
      checks++; if (per_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", per_req); end
      checks++; if (per_address !== 32'h0) begin errors++; $display("FAIL reset_per_addr: got %h want 0", per_address); end
      checks++; if (per_we !== 1'b0) begin errors++; $display("FAIL reset_per_we: got %b want 0", per_we); end
      checks++; if (per_wdata !== 32'h0) begin errors++; $display("FAIL reset_per_data: got %h want 0", per_wdata); end
      checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_cpu_data: got %h want 0", cpu_rdata); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
   endtask

   task automatic test_write();
      int h, r, ra; logic [31:0] a, d, dd; logic w, t;
      run_access(32'h9004, 1'b1, 32'h1234, 0, 32'h0BAD, 20, h, r, ra, a, w, d, dd, t);
      checks++; if (h != 3) begin errors++; $display("FAIL write_halt_cycles: got %0d want 3", h); end
      checks++; if (r != 1) begin errors++; $display("FAIL write_req_count: got %0d want 1", r); end
      checks++; if (ra != 1) begin errors++; $display("FAIL write_req_cycle: got %0d want 1", ra); end
      checks++; if (a !== 32'h9004) begin errors++; $display("FAIL write_req_addr: got %h want 9004", a); end
      checks++; if (w !== 1'b1) begin errors++; $display("FAIL write_req_we: got %b want 1", w); end
      checks++; if (d !== 32'h1234) begin errors++; $display("FAIL write_req_data: got %h want 1234", d); end
      checks++; if (dd !== 32'h0BAD) begin errors++; $display("FAIL write_capture: got %h want 0bad", dd); end
   endtask

   task automatic test_read_busy();
      int h, r, ra; logic [31:0] a, d, dd; logic w, t;
      run_access(32'h9010, 1'b0, 32'h0, 5, 32'hCAFE, 30, h, r, ra, a, w, d, dd, t);
      checks++; if (h != 8) begin errors++; $display("FAIL read_halt_cycles: got %0d want 8", h); end
      checks++; if (r != 1) begin errors++; $display("FAIL read_req_count: got %0d want 1", r); end
      checks++; if (a !== 32'h9010) begin errors++; $display("FAIL read_req_addr: got %h want 9010", a); end
      checks++; if (w !== 1'b0) begin errors++; $display("FAIL read_req_we: got %b want 0", w); end
      checks++; if (dd !== 32'hCAFE) begin errors++; $display("FAIL read_data: got %h want cafe", dd); end
   endtask

   task automatic test_window_edges();
      int h, r, ra; logic [31:0] a, d, dd; logic w, t;
      run_access(32'h8FFF, 1'b0, 32'h0, 0, 32'h0, 5, h, r, ra, a, w, d, dd, t);
      checks++; if (h != 0 || r != 0) begin errors++; $display("FAIL below_window: halt=%0d req=%0d want 0/0", h, r); end
      run_access(32'h9100, 1'b0, 32'h0, 0, 32'h0, 5, h, r, ra, a, w, d, dd, t);
      checks++; if (h != 0 || r != 0) begin errors++; $display("FAIL above_window: halt=%0d req=%0d want 0/0", h, r); end
      run_access(32'h90FF, 1'b0, 32'h0, 0, 32'h7777, 20, h, r, ra, a, w, d, dd, t);
      checks++; if (h != 3 || r != 1) begin errors++; $display("FAIL last_addr_hit: halt=%0d req=%0d want 3/1", h, r); end
      checks++; if (dd !== 32'h7777) begin errors++; $display("FAIL last_addr_data: got %h want 7777", dd); end
   endtask

   task automatic test_back_to_back();
      int h, r, ra; logic [31:0] a, d, dd; logic w, t;
      run_access(32'h9004, 1'b0, 32'h0, 0, 32'h1111, 20, h, r, ra, a, w, d, dd, t);
      checks++; if (h != 3 || r != 1) begin errors++; $display("FAIL b2b_first: halt=%0d req=%0d want 3/1", h, r); end
      run_access(32'h9004, 1'b0, 32'h0, 0, 32'h2222, 5, h, r, ra, a, w, d, dd, t);
      checks++; if (h != 0 || r != 0) begin errors++; $display("FAIL b2b_held: halt=%0d req=%0d want 0/0", h, r); end
      checks++; if (cpu_rdata !== 32'h1111) begin errors++; $display("FAIL b2b_data_hold: got %h want 1111", cpu_rdata); end
      run_access(32'h9008, 1'b0, 32'h0, 0, 32'h3333, 20, h, r, ra, a, w, d, dd, t);
      checks++; if (h != 3 || r != 1 || a !== 32'h9008) begin
         errors++; $display("FAIL b2b_new_addr: halt=%0d req=%0d addr=%h want 3/1/9008", h, r, a);
      end
      run_access(32'h9004, 1'b0, 32'h0, 0, 32'h4444, 20, h, r, ra, a, w, d, dd, t);
      checks++; if (h != 3 || r != 1 || dd !== 32'h4444) begin
         errors++; $display("FAIL b2b_return: halt=%0d req=%0d data=%h want 3/1/4444", h, r, dd);
      end
   endtask

   task automatic test_timeout();
      int h, r, ra; logic [31:0] a, d, dd; logic w, t;
`ifdef BUS_STALL_TIMEOUT_EN
      run_access(32'h9020, 1'b0, 32'h0, 1000, 32'h5555, 64, h, r, ra, a, w, d, dd, t);
      checks++; if (h != 18) begin errors++; $display("FAIL timeout_halt_cycles: got %0d want 18", h); end
      checks++; if (dd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL timeout_data: got %h want ffffffff", dd); end
      checks++; if (t !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b want 1", t); end
      run_access(32'h9030, 1'b1, 32'h9, 0, 32'h6666, 20, h, r, ra, a, w, d, dd, t);
      checks++; if (h != 3 || dd !== 32'h6666) begin
         errors++; $display("FAIL timeout_next_access: halt=%0d data=%h want 3/6666", h, dd);
      end
      checks++; if (t !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b want 1", t); end
`else
      run_access(32'h9020, 1'b0, 32'h0, 40, 32'h5555, 64, h, r, ra, a, w, d, dd, t);
      checks++; if (h != 43) begin errors++; $display("FAIL long_wait_halt_cycles: got %0d want 43", h); end
      checks++; if (t !== 1'b0 || dd !== 32'h5555) begin
         errors++; $display("FAIL long_wait_result: timeout=%b data=%h want 0/5555", t, dd);
      end
`endif
   endtask

   task automatic test_reset_mid_access();
      int h, r, ra; logic [31:0] a, d, dd; logic w, t;
      @(posedge clk); #1;
      cpu_address = 32'h9040; cpu_we = 1'b0; per_busy = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      // now in the second WAIT cycle; the CPU is reset alongside the bridge
      reset = 1'b1; cpu_address = 32'h0;
      @(posedge clk); #1;
      reset = 1'b0; per_busy = 1'b0;
      @(negedge clk);
      checks++; if (cpu_halt !== 1'b0) begin errors++; $display("FAIL rst_mid_halt: got %b want 0", cpu_halt); end
      checks++; if (per_req !== 1'b0) begin errors++; $display("FAIL rst_mid_req: got %b want 0", per_req); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_mid_timeout: got %b want 0", timeout); end
      run_access(32'h9040, 1'b0, 32'h0, 0, 32'h5A5A, 20, h, r, ra, a, w, d, dd, t);
      checks++; if (h != 3 || r != 1 || dd !== 32'h5A5A) begin
         errors++; $display("FAIL rst_mid_recover: halt=%0d req=%0d data=%h want 3/1/5a5a", h, r, dd);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_busy();
      test_window_edges();
      test_back_to_back();
      test_timeout();
      test_reset_mid_access();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running want finished");
      $fatal(1);
   end

endmodule
